// File: rtl/branch_phb_pkg.sv
// Shared sizes, queue entry layout and counter update helper for the PHB.
// Optional gshare indexing is enabled by defining PHB_GSHARE_EN.
package branch_phb_pkg;

   localparam int PCBUS_W        = 64;
   localparam int PHB_DEPTH      = 16;
   localparam int PHB_IDX_W      = 4;
   localparam int PHB_CNT_W      = 2;
   localparam int PHB_FIFO_DEPTH = 4;
   localparam int PHB_PTR_W      = 2;
   localparam int PHB_OCC_W      = 3;
   localparam int PHB_ENTRY_W    = PHB_IDX_W + 1;

   localparam logic [PHB_CNT_W-1:0] PHB_CNT_RST = 2'b01;

   typedef struct packed {
      logic [PHB_IDX_W-1:0] idx;
      logic                 taken;
   } phb_upd_t;

   function automatic logic [PHB_CNT_W-1:0] phb_cnt_next(input logic [PHB_CNT_W-1:0] cnt,
                                                         input logic taken);
      logic [PHB_CNT_W-1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != 2'b11) nxt = cnt + 2'd1;
      end else begin
         if (cnt != 2'b00) nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/phb_upd_fifo.sv
// Four-entry update queue with two write ports (slot 1 ahead of slot 2) and one read port.
// Occupancy is kept as a separate 3-bit count so full and empty stay distinct.
module phb_upd_fifo
   import branch_phb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr1_en,
   input  logic [PHB_ENTRY_W-1:0] wr1_data,
   input  logic                   wr2_en,
   input  logic [PHB_ENTRY_W-1:0] wr2_data,
   input  logic                   rd_en,
   output logic [PHB_ENTRY_W-1:0] rd_data,
   output logic [PHB_OCC_W-1:0]   occ
);

   logic [PHB_ENTRY_W-1:0] mem [PHB_FIFO_DEPTH];
   logic [PHB_PTR_W-1:0]   wr_ptr;
   logic [PHB_PTR_W-1:0]   rd_ptr;
   logic [1:0]             enq_cnt;
   logic                   deq;

   assign enq_cnt = {1'b0, wr1_en} + {1'b0, wr2_en};
   assign deq     = rd_en && (occ != '0);
   assign rd_data = mem[rd_ptr];

   // A lone slot-2 write takes the next free slot rather than leaving a hole.
   always_ff @(posedge clk) begin
      if (wr1_en) mem[wr_ptr] <= wr1_data;
      if (wr2_en) mem[wr1_en ? wr_ptr + 2'd1 : wr_ptr] <= wr2_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         wr_ptr <= wr_ptr + enq_cnt;
         rd_ptr <= rd_ptr + {1'b0, deq};
         occ    <= occ + {1'b0, enq_cnt} - {2'b00, deq};
      end
   end

endmodule

// File: rtl/branch_phb.sv
// Pattern history table: 16 two-bit counters trained through a small update queue.
// Define PHB_GSHARE_EN to XOR a 4-bit global history into the lookup and write indices.
module branch_phb
   import branch_phb_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         phb_addr,
   output logic               phb_ena,
   input  logic               upd1_valid,
   input  logic [PCBUS_W-1:0] upd1_pc,
   input  logic               upd1_taken,
   input  logic               upd2_valid,
   input  logic [PCBUS_W-1:0] upd2_pc,
   input  logic               upd2_taken,
   output logic               upd_ready,
   output logic [7:0]         upd_drop_cnt
);

   logic [PHB_CNT_W-1:0]   cnt_table [PHB_DEPTH];
   logic [PHB_OCC_W-1:0]   occ;
   logic [PHB_ENTRY_W-1:0] rd_data;
   phb_upd_t               head;
   logic                   enq1;
   logic                   enq2;
   logic                   drain;
   logic [PHB_IDX_W-1:0]   lookup_idx;
   logic [PHB_IDX_W-1:0]   write_idx;
   logic [1:0]             drop_inc;
   logic [8:0]             drop_sum;
   logic                   unused_pc_bits;

   assign unused_pc_bits = ^{upd1_pc[PCBUS_W-1:6], upd1_pc[1:0], upd2_pc[PCBUS_W-1:6], upd2_pc[1:0]};

   // Two free slots are required so a dual issue can never overflow the queue.
   assign upd_ready = (occ <= 3'd2);
   assign enq1      = upd_ready && upd1_valid;
   assign enq2      = upd_ready && upd2_valid;
   assign drain     = (occ != '0) && !rst;
   assign head      = phb_upd_t'(rd_data);

   phb_upd_fifo u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr1_en   (enq1),
      .wr1_data ({upd1_pc[5:2], upd1_taken}),
      .wr2_en   (enq2),
      .wr2_data ({upd2_pc[5:2], upd2_taken}),
      .rd_en    (drain),
      .rd_data  (rd_data),
      .occ      (occ)
   );

`ifdef PHB_GSHARE_EN
   logic [PHB_IDX_W-1:0] ghr;

   assign lookup_idx = phb_addr ^ ghr;
   assign write_idx  = head.idx ^ ghr;

   always_ff @(posedge clk) begin
      if (rst)        ghr <= '0;
      else if (drain) ghr <= {ghr[PHB_IDX_W-2:0], head.taken};
   end
`else
   assign lookup_idx = phb_addr;
   assign write_idx  = head.idx;
`endif

   // Lookup reads committed state only, so a same-cycle drain is seen one cycle later.
   assign phb_ena = cnt_table[lookup_idx][1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PHB_DEPTH; i++) cnt_table[i] <= PHB_CNT_RST;
      end else if (drain) begin
         cnt_table[write_idx] <= phb_cnt_next(cnt_table[write_idx], head.taken);
      end
   end

   assign drop_inc = {1'b0, !upd_ready && upd1_valid} + {1'b0, !upd_ready && upd2_valid};
   assign drop_sum = {1'b0, upd_drop_cnt} + {7'b0, drop_inc};

   always_ff @(posedge clk) begin
      if (rst) upd_drop_cnt <= '0;
      else     upd_drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

endmodule

// File: tb/tb_branch_phb.sv
// Directed self-checking bench for branch_phb: reset, training, saturation,
// back-pressure, same-cycle hazard, mid-operation reset and (with PHB_GSHARE_EN) gshare.
module tb_branch_phb;

   logic        clk;
   logic        rst;
   logic [3:0]  phb_addr;
   logic        phb_ena;
   logic        upd1_valid;
   logic [63:0] upd1_pc;
   logic        upd1_taken;
   logic        upd2_valid;
   logic [63:0] upd2_pc;
   logic        upd2_taken;
   logic        upd_ready;
   logic [7:0]  upd_drop_cnt;

   int checks = 0;
   int errors = 0;

   branch_phb dut (
      .clk          (clk),
      .rst          (rst),
      .phb_addr     (phb_addr),
      .phb_ena      (phb_ena),
      .upd1_valid   (upd1_valid),
      .upd1_pc      (upd1_pc),
      .upd1_taken   (upd1_taken),
      .upd2_valid   (upd2_valid),
      .upd2_pc      (upd2_pc),
      .upd2_taken   (upd2_taken),
      .upd_ready    (upd_ready),
      .upd_drop_cnt (upd_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pc_of(input logic [3:0] idx);
      return 64'h0000_0000_8000_0000 | (64'(idx) << 2);
   endfunction

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 ns later.
   task automatic apply_stimulus(input logic v1, input logic [3:0] i1, input logic t1,
                                 input logic v2, input logic [3:0] i2, input logic t2);
      @(negedge clk);
      upd1_valid = v1;
      upd1_pc    = pc_of(i1);
      upd1_taken = t1;
      upd2_valid = v2;
      upd2_pc    = pc_of(i2);
      upd2_taken = t2;
      #1;
   endtask

   task automatic idle();
      apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic settle();
      idle();
      idle();
   endtask

   task automatic look(input logic [3:0] addr, input logic exp, input string tag);
      phb_addr = addr;
      #1;
      check_output(tag, {7'b0, phb_ena}, {7'b0, exp});
   endtask

   initial begin
      rst        = 1'b1;
      phb_addr   = 4'd0;
      upd1_valid = 1'b0;
      upd1_pc    = '0;
      upd1_taken = 1'b0;
      upd2_valid = 1'b0;
      upd2_pc    = '0;
      upd2_taken = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      $display("[TB] reset checks");
      for (int i = 0; i < 16; i++) look(4'(i), 1'b0, "reset_ena");
      check_output("reset_ready", {7'b0, upd_ready}, 8'd1);
      check_output("reset_drop", upd_drop_cnt, 8'd0);

      $display("[TB] training idx 5");
      phb_addr = 4'd5;
      apply_stimulus(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
      look(4'd5, 1'b0, "train_cycle0");
      apply_stimulus(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
      look(4'd5, 1'b0, "train_cycle1");
      idle();
      look(4'd5, 1'b1, "train_cycle2");
      idle();
      look(4'd5, 1'b1, "train_cycle3");

      $display("[TB] saturation idx 5");
      repeat (3) apply_stimulus(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
      settle();
      look(4'd5, 1'b1, "sat_top_hold");
      apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0);
      settle();
      look(4'd5, 1'b1, "sat_11_to_10");
      apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0);
      settle();
      look(4'd5, 1'b0, "sat_10_to_01");
      repeat (2) apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0);
      settle();
      look(4'd5, 1'b0, "sat_at_00");
      apply_stimulus(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
      settle();
      look(4'd5, 1'b0, "sat_floor_then_taken");
      apply_stimulus(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
      settle();
      look(4'd5, 1'b1, "sat_floor_taken_twice");
      check_output("sat_no_drops", upd_drop_cnt, 8'd0);

      $display("[TB] dual issue and back-pressure");
      apply_stimulus(1'b1, 4'd8, 1'b1, 1'b1, 4'd9, 1'b1);
      check_output("dual_c0_ready", {7'b0, upd_ready}, 8'd1);
      apply_stimulus(1'b1, 4'd8, 1'b1, 1'b1, 4'd9, 1'b1);
      check_output("dual_c1_ready", {7'b0, upd_ready}, 8'd1);
      apply_stimulus(1'b1, 4'd8, 1'b1, 1'b1, 4'd9, 1'b1);
      check_output("dual_c2_ready", {7'b0, upd_ready}, 8'd0);
      look(4'd8, 1'b1, "dual_order_upd1_first");
      look(4'd9, 1'b0, "dual_order_upd2_later");
      idle();
      check_output("dual_drop_cnt", upd_drop_cnt, 8'd2);
      check_output("dual_c3_ready", {7'b0, upd_ready}, 8'd1);
      look(4'd9, 1'b1, "dual_upd2_drained");
      repeat (3) idle();

      $display("[TB] drop counter saturation");
      repeat (300) apply_stimulus(1'b1, 4'd12, 1'b1, 1'b1, 4'd13, 1'b0);
      repeat (4) idle();
      check_output("drop_saturate", upd_drop_cnt, 8'hFF);
      check_output("drop_ready_after", {7'b0, upd_ready}, 8'd1);

      $display("[TB] same-cycle hazard idx 3");
      apply_stimulus(1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
      idle();
      look(4'd3, 1'b0, "hazard_same_cycle");
      idle();
      look(4'd3, 1'b1, "hazard_next_cycle");

      $display("[TB] mid-operation reset");
      apply_stimulus(1'b1, 4'd10, 1'b1, 1'b0, 4'd0, 1'b0);
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      look(4'd10, 1'b0, "midrst_no_write");
      look(4'd5, 1'b0, "midrst_table_reset");
      check_output("midrst_drop", upd_drop_cnt, 8'd0);
      check_output("midrst_ready", {7'b0, upd_ready}, 8'd1);
      settle();
      look(4'd10, 1'b0, "midrst_queue_dropped");

`ifdef PHB_GSHARE_EN
      $display("[TB] gshare history");
      apply_stimulus(1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
      apply_stimulus(1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
      apply_stimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      apply_stimulus(1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      settle();
      look(4'h3, 1'b0, "gshare_addr3_entryF");
      look(4'hC, 1'b1, "gshare_addrC_entry0");
      look(4'hD, 1'b1, "gshare_addrD_entry1");
      look(4'hA, 1'b0, "gshare_addrA_entry6");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
